// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, widths and capture FSM states.
package vga_timing_pkg;
   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_TOTAL     = 525;
   localparam int unsigned H_ACT_START = 144;
   localparam int unsigned H_ACT_END   = 783;
   localparam int unsigned V_ACT_START = 34;
   localparam int unsigned V_ACT_END   = 513;
   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam int unsigned ADDR_W      = 19;
   localparam int unsigned PIX_W       = 8;
   localparam int unsigned ENTRY_W     = ADDR_W + PIX_W;
   typedef enum logic [1:0] {SEARCH, IDLE, CAPTURE, DRAIN} cap_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of {addr,pixel} entries; a push on full succeeds when a pop happens in the same cycle.
module pixel_fifo
   import vga_timing_pkg::*;
#(
   parameter int unsigned W     = ENTRY_W,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + AW'(do_push);
         rd_q  <= rd_q + AW'(do_pop);
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !flush_i) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: locks onto a VGA sync stream and writes one armed frame's pixels to memory through a small FIFO.
module vga_frame_capture
   import vga_timing_pkg::*;
#(
   parameter int unsigned HTOT = H_TOTAL,
   parameter int unsigned VTOT = V_TOTAL,
   parameter int unsigned HS   = H_ACT_START,
   parameter int unsigned HE   = H_ACT_END,
   parameter int unsigned VS   = V_ACT_START,
   parameter int unsigned VE   = V_ACT_END
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_en,
   input  logic              hsync,
   input  logic              vsync,
   input  logic [2:0]        VGA_R,
   input  logic [2:0]        VGA_G,
   input  logic [1:0]        VGA_B,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_data,
   output logic              mem_we,
   input  logic              mem_ready,
   output logic              locked,
   output logic              frame_done,
   output logic              overflow,
   output logic              sync_error
);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'((HE - HS + 1) * (VE - VS + 1) - 1);
   localparam logic [9:0]        H_LAST = 10'(HTOT - 1);
   localparam logic [9:0]        V_LAST = 10'(VTOT - 1);
   cap_state_e         state_q, state_d;
   logic               hs_q, hs_p_q, vs_q, vs_p_q, hfall, vfall;
   logic [PIX_W-1:0]   pix_q;
   logic [9:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic               vpend_q, vpend_d, seen_q, seen_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               push_q, push_d, ovf_q, ovf_d, done_q, done_d, serr_q;
   logic [ENTRY_W-1:0] pdat_q, head;
   logic               err, act, pop, full, empty;
   always_comb begin
      hfall   = !hs_q && hs_p_q;
      vfall   = !vs_q && vs_p_q;
      hcnt_d  = hfall ? 10'd0 : (hcnt_q == 10'h3FF ? hcnt_q : hcnt_q + 10'd1);
      vcnt_d  = hfall ? ((vpend_q || vfall) ? 10'd0 : vcnt_q + 10'd1) : vcnt_q;
      vpend_d = !hfall && (vfall || vpend_q);
      // vcnt_q is still the previous line's count when the vsync edge arrives
      err     = (hfall && hcnt_q != H_LAST) || (hcnt_d == 10'h3FF && hcnt_q != 10'h3FF) ||
                (vfall && vcnt_q != V_LAST);
      act     = state_q == CAPTURE && hcnt_d >= 10'(HS) && hcnt_d <= 10'(HE) &&
                vcnt_d >= 10'(VS) && vcnt_d <= 10'(VE);
      seen_d  = vfall || (seen_q && !err);
      pop     = !empty && mem_ready;
      state_d = state_q;
      addr_d  = addr_q;
      push_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = ovf_q || (push_q && full && !pop);
      if (err) state_d = SEARCH;
      else
         case (state_q)
            SEARCH:  if (vfall && seen_q) state_d = IDLE;
            IDLE:    if (vfall && capture_en) begin
               state_d = CAPTURE;
               addr_d  = '0;
               ovf_d   = 1'b0;
            end
            CAPTURE: if (act) begin
               push_d  = 1'b1;
               state_d = addr_q == LAST ? DRAIN : CAPTURE;
               addr_d  = addr_q == LAST ? addr_q : addr_q + 1'b1;
            end
            default: if (empty && !push_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hs_q    <= 1'b1;
         hs_p_q  <= 1'b1;
         vs_q    <= 1'b1;
         vs_p_q  <= 1'b1;
         pix_q   <= '0;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         vpend_q <= 1'b0;
         seen_q  <= 1'b0;
         state_q <= SEARCH;
         addr_q  <= '0;
         push_q  <= 1'b0;
         pdat_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         hs_q    <= hsync;
         hs_p_q  <= hs_q;
         vs_q    <= vsync;
         vs_p_q  <= vs_q;
         pix_q   <= {VGA_R, VGA_G, VGA_B};
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         vpend_q <= vpend_d;
         seen_q  <= seen_d;
         state_q <= state_d;
         addr_q  <= addr_d;
         push_q  <= push_d;
         pdat_q  <= {addr_q, pix_q};
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         serr_q  <= err;
      end
   pixel_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (err),
      .push_i  (push_q),
      .pop_i   (pop),
      .din_i   (pdat_q),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );
   assign mem_we     = !empty;
   assign mem_addr   = empty ? '0 : head[ENTRY_W-1:PIX_W];
   assign mem_data   = empty ? '0 : head[PIX_W-1:0];
   assign locked     = state_q != SEARCH;
   assign frame_done = done_q;
   assign overflow   = ovf_q;
   assign sync_error = serr_q;
endmodule
